// File: rtl/ref_fetch_addr_gen_if.sv
`default_nettype none
// ------------------------------------------------------------------
// ref_fetch_addr_gen_if : MV request and reference-address handshakes
// Rev 1.0
// ------------------------------------------------------------------
interface ref_fetch_addr_gen_if #(
  parameter int ADDR_W = 17
);
  logic                mv_valid;
  logic                mv_ready;
  logic signed [14:0]  mv_x_int;
  logic signed [14:0]  mv_y_int;
  logic [3:0]          mv_x_frac;
  logic [3:0]          mv_y_frac;
  logic                interp_x;
  logic                interp_y;
  logic [11:0]         blk_x;
  logic [11:0]         blk_y;
  logic                addr_valid;
  logic                addr_ready;
  logic [ADDR_W-1:0]   addr;
  logic                addr_eol;
  logic                addr_last;
  logic [3:0]          frac_x;
  logic [3:0]          frac_y;
  logic                out_interp_x;
  logic                out_interp_y;

  modport slave (
    input  mv_valid, mv_x_int, mv_y_int, mv_x_frac, mv_y_frac,
           interp_x, interp_y, blk_x, blk_y, addr_ready,
    output mv_ready, addr_valid, addr, addr_eol, addr_last,
           frac_x, frac_y, out_interp_x, out_interp_y
  );

  modport master (
    output mv_valid, mv_x_int, mv_y_int, mv_x_frac, mv_y_frac,
           interp_x, interp_y, blk_x, blk_y, addr_ready,
    input  mv_ready, addr_valid, addr, addr_eol, addr_last,
           frac_x, frac_y, out_interp_x, out_interp_y
  );
endinterface
`default_nettype wire

// File: rtl/ref_fetch_addr_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// ref_fetch_addr_gen : raster address stream for a 4x4 block's MC window.
// Optional FETCH_CLAMP_EN pads out-of-picture samples. Rev 1.0
// ------------------------------------------------------------------
module ref_fetch_addr_gen #(
  parameter int PIC_W  = 416,
  parameter int PIC_H  = 240,
  parameter int ADDR_W = 17
) (
  input  logic                 clk_i,
  input  logic                 rst_async_i,
  ref_fetch_addr_gen_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FETCH = 1'b1
  } state_t;

  localparam logic signed [31:0] c_PIC_W = 32'(PIC_W);
`ifdef FETCH_CLAMP_EN
  localparam logic signed [16:0] c_X_MAX = 17'(PIC_W - 1);
  localparam logic signed [16:0] c_Y_MAX = 17'(PIC_H - 1);
`endif

  state_t             state_q, state_d;
  logic signed [16:0] x0_q, x0_d, y0_q, y0_d;
  logic [3:0]         wm1_q, wm1_d, hm1_q, hm1_d;
  logic [3:0]         col_q, col_d, row_q, row_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               eol_q, eol_d, last_q, last_d;
  logic [3:0]         fx_q, fx_d, fy_q, fy_d;
  logic               ix_q, ix_d, iy_q, iy_d;

  logic               w_adv;
  logic signed [16:0] w_x0_new, w_y0_new, w_x, w_y;
  logic signed [31:0] w_lin;

  assign w_x0_new = $signed({5'd0, bus.blk_x})
                  + $signed({{2{bus.mv_x_int[14]}}, bus.mv_x_int})
                  - (bus.interp_x ? 17'sd3 : 17'sd0);
  assign w_y0_new = $signed({5'd0, bus.blk_y})
                  + $signed({{2{bus.mv_y_int[14]}}, bus.mv_y_int})
                  - (bus.interp_y ? 17'sd3 : 17'sd0);

  always_ff @(posedge clk_i or posedge rst_async_i) begin
    if (rst_async_i) begin
      state_q <= ST_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      wm1_q   <= '0;
      hm1_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      eol_q   <= 1'b0;
      last_q  <= 1'b0;
      fx_q    <= '0;
      fy_q    <= '0;
      ix_q    <= 1'b0;
      iy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      wm1_q   <= wm1_d;
      hm1_q   <= hm1_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      eol_q   <= eol_d;
      last_q  <= last_d;
      fx_q    <= fx_d;
      fy_q    <= fy_d;
      ix_q    <= ix_d;
      iy_q    <= iy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    wm1_d   = wm1_q;
    hm1_d   = hm1_q;
    col_d   = col_q;
    row_d   = row_q;
    fx_d    = fx_q;
    fy_d    = fy_q;
    ix_d    = ix_q;
    iy_d    = iy_q;
    w_adv   = 1'b0;
    bus.mv_ready   = (state_q == ST_IDLE);
    bus.addr_valid = (state_q == ST_FETCH);
    case (state_q)
      ST_IDLE: begin
        if (bus.mv_valid) begin
          state_d = ST_FETCH;
          x0_d    = w_x0_new;
          y0_d    = w_y0_new;
          wm1_d   = bus.interp_x ? 4'd10 : 4'd3;
          hm1_d   = bus.interp_y ? 4'd10 : 4'd3;
          col_d   = '0;
          row_d   = '0;
          fx_d    = bus.mv_x_frac;
          fy_d    = bus.mv_y_frac;
          ix_d    = bus.interp_x;
          iy_d    = bus.interp_y;
          w_adv   = 1'b1;
        end
      end
      ST_FETCH: begin
        if (bus.addr_ready) begin
          if (last_q) begin
            state_d = ST_IDLE;
          end else begin
            w_adv = 1'b1;
            if (eol_q) begin
              col_d = '0;
              row_d = row_q + 4'd1;
            end else begin
              col_d = col_q + 4'd1;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address of the sample the counters will point at next cycle, so ADDR is a pure register.
  always_comb begin
    w_x = x0_d + $signed({13'd0, col_d});
    w_y = y0_d + $signed({13'd0, row_d});
`ifdef FETCH_CLAMP_EN
    if (w_x < 17'sd0)        w_x = 17'sd0;
    else if (w_x > c_X_MAX)  w_x = c_X_MAX;
    if (w_y < 17'sd0)        w_y = 17'sd0;
    else if (w_y > c_Y_MAX)  w_y = c_Y_MAX;
`endif
    w_lin  = 32'(w_y) * c_PIC_W + 32'(w_x);
    addr_d = w_adv ? ADDR_W'(w_lin) : addr_q;
    eol_d  = w_adv ? (col_d == wm1_d) : eol_q;
    last_d = w_adv ? ((col_d == wm1_d) && (row_d == hm1_d)) : last_q;
  end

  assign bus.addr         = addr_q;
  assign bus.addr_eol     = eol_q;
  assign bus.addr_last    = last_q;
  assign bus.frac_x       = fx_q;
  assign bus.frac_y       = fy_q;
  assign bus.out_interp_x = ix_q;
  assign bus.out_interp_y = iy_q;

endmodule
`default_nettype wire

// File: tb/tb_ref_fetch_addr_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_ref_fetch_addr_gen : scoreboard bench for ref_fetch_addr_gen
// Rev 1.0
// ------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ref_fetch_addr_gen;
  localparam int PIC_W  = 416;
  localparam int PIC_H  = 240;
  localparam int ADDR_W = 17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ref_fetch_addr_gen_if #(.ADDR_W(ADDR_W)) bus ();

  ref_fetch_addr_gen #(.PIC_W(PIC_W), .PIC_H(PIC_H), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .rst_async_i (rst),
    .bus         (bus)
  );

  typedef struct {
    int addr;
    bit eol;
    bit last;
    int idx;
    int fx;
    int fy;
    bit ix;
    bit iy;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   hs_total = 0;
  int   first_addr = -1;
  int   last_addr = -1;
  int   win_len = 0;
  int   stall_token = 0;
  bit   rand_ready = 1'b0;
  int   base = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Reference model: enumerate the window straight from its geometry.
  task automatic push_window(input int bx, input int by, input int mx, input int my,
                             input int fx, input int fy, input bit ix, input bit iy);
    int x0, y0, w, h, x, y;
    exp_t e;
    x0 = bx + mx - (ix ? 3 : 0);
    y0 = by + my - (iy ? 3 : 0);
    w  = ix ? 11 : 4;
    h  = iy ? 11 : 4;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        x = x0 + c;
        y = y0 + r;
`ifdef FETCH_CLAMP_EN
        x = (x < 0) ? 0 : ((x > PIC_W - 1) ? PIC_W - 1 : x);
        y = (y < 0) ? 0 : ((y > PIC_H - 1) ? PIC_H - 1 : y);
`endif
        e.addr = (y * PIC_W + x) & ((1 << ADDR_W) - 1);
        e.eol  = (c == w - 1);
        e.last = (c == w - 1) && (r == h - 1);
        e.idx  = r * w + c;
        e.fx   = fx;
        e.fy   = fy;
        e.ix   = ix;
        e.iy   = iy;
        q.push_back(e);
      end
    end
  endtask

  task automatic issue(input int bx, input int by, input int mx, input int my,
                       input int fx, input int fy, input bit ix, input bit iy, input bit hold);
    int n;
    bus.mv_valid  = 1'b1;
    bus.blk_x     = 12'(bx);
    bus.blk_y     = 12'(by);
    bus.mv_x_int  = 15'(mx);
    bus.mv_y_int  = 15'(my);
    bus.mv_x_frac = 4'(fx);
    bus.mv_y_frac = 4'(fy);
    bus.interp_x  = ix;
    bus.interp_y  = iy;
    n = 0;
    while (!bus.mv_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.mv_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout actual=%0d required=1", bus.mv_ready);
      bus.mv_valid = 1'b0;
    end else begin
      push_window(bx, by, mx, my, fx, fy, ix, iy);
      base = hs_total;
      @(posedge clk);
      #1;
      if (!hold) bus.mv_valid = 1'b0;
      @(negedge clk);
      chk("latency1_valid", bus.addr_valid, 1);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!(q.size() == 0 && bus.mv_ready && !bus.addr_valid) && n < 5000);
    chk("drain_queue_empty", q.size(), 0);
  endtask

  // Address-side ready driver: always, random, or a scripted 3-cycle stall.
  initial begin
    int seen;
    int stall_left;
    seen = 0;
    stall_left = 0;
    bus.addr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_token != seen) begin
        seen = stall_token;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        bus.addr_ready = 1'b0;
        stall_left--;
      end else if (rand_ready) begin
        bus.addr_ready = ($urandom_range(0, 3) != 0);
      end else begin
        bus.addr_ready = 1'b1;
      end
    end
  end

  // Monitor: pops the scoreboard on each address handshake.
  initial begin
    exp_t              e;
    logic [ADDR_W-1:0] pa;
    logic              pe, pl;
    bit                stalled;
    bit                after_last;
    stalled = 1'b0;
    after_last = 1'b0;
    pa = '0;
    pe = 1'b0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stalled = 1'b0;
        after_last = 1'b0;
        continue;
      end
      if (after_last) begin
        chk("idle_gap_valid", bus.addr_valid, 0);
        chk("idle_gap_mv_ready", bus.mv_ready, 1);
        after_last = 1'b0;
      end
      if (stalled && bus.addr_valid) begin
        chk("stall_addr", bus.addr, pa);
        chk("stall_eol", bus.addr_eol, pe);
        chk("stall_last", bus.addr_last, pl);
      end
      if (bus.addr_valid) chk("mv_ready_busy", bus.mv_ready, 0);
      stalled = bus.addr_valid && !bus.addr_ready;
      pa = bus.addr;
      pe = bus.addr_eol;
      pl = bus.addr_last;
      if (bus.addr_valid && bus.addr_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_addr actual=%0d required=none", bus.addr);
        end else begin
          e = q.pop_front();
          chk("addr", bus.addr, e.addr);
          chk("eol", bus.addr_eol, e.eol);
          chk("last", bus.addr_last, e.last);
          chk("frac_x", bus.frac_x, e.fx);
          chk("frac_y", bus.frac_y, e.fy);
          chk("interp_x", bus.out_interp_x, e.ix);
          chk("interp_y", bus.out_interp_y, e.iy);
          hs_total++;
          if (e.idx == 0) first_addr = int'(bus.addr);
          if (e.last) begin
            last_addr = int'(bus.addr);
            win_len = e.idx + 1;
            after_last = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.mv_valid = 1'b0;
    bus.blk_x = '0;
    bus.blk_y = '0;
    bus.mv_x_int = '0;
    bus.mv_y_int = '0;
    bus.mv_x_frac = '0;
    bus.mv_y_frac = '0;
    bus.interp_x = 1'b0;
    bus.interp_y = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_addr_valid", bus.addr_valid, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mv_ready", bus.mv_ready, 1);
    chk("rst_addr", bus.addr, 0);
    chk("rst_eol", bus.addr_eol, 0);
    chk("rst_last", bus.addr_last, 0);
    chk("rst_frac", {bus.frac_x, bus.frac_y}, 0);
    chk("rst_interp", {bus.out_interp_x, bus.out_interp_y}, 0);

    // Plain 4x4 window.
    issue(8, 4, 2, 1, 5, 7, 0, 0, 0);
    wait_done();
    chk("w4_first", first_addr, 2090);
    chk("w4_last", last_addr, 3341);
    chk("w4_len", win_len, 16);

    // Both-direction interpolation, 11x11.
    issue(16, 16, 0, 0, 3, 9, 1, 1, 0);
    wait_done();
    chk("w11_first", first_addr, 5421);
    chk("w11_last", last_addr, 9591);
    chk("w11_len", win_len, 121);

`ifdef FETCH_CLAMP_EN
    issue(0, 0, -5, -5, 1, 2, 1, 1, 0);
    wait_done();
    chk("clamp_first", first_addr, 0);
    chk("clamp_last", last_addr, 834);
`endif

    // Three-cycle ready stall right after the 5th address.
    issue(8, 4, 2, 1, 11, 12, 0, 0, 0);
    n = 0;
    while (hs_total - base < 5 && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("stall_reach5", hs_total - base, 5);
    stall_token++;
    wait_done();
    chk("stall_len", win_len, 16);
    chk("stall_last_addr", last_addr, 3341);

    // Reset in the middle of a window.
    rand_ready = 1'b1;
    issue(100, 50, 3, -2, 6, 6, 1, 0, 0);
    n = 0;
    while (hs_total - base < 5 && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rst_reach5", hs_total - base, 5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid_now", bus.addr_valid, 0);
    q.delete();
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    chk("midrst_mv_ready", bus.mv_ready, 1);
    chk("midrst_valid", bus.addr_valid, 0);
    chk("midrst_addr", bus.addr, 0);
    issue(8, 4, 2, 1, 4, 4, 0, 0, 0);
    wait_done();
    chk("midrst_new_first", first_addr, 2090);

    // Two requests with MV_VALID held high across both.
    issue(16, 16, 0, 0, 13, 14, 1, 1, 1);
    issue(8, 4, 2, 1, 2, 3, 0, 0, 0);
    wait_done();

    // Randomized requests, some back-to-back.
    for (int i = 0; i < 12; i++) begin
      issue($urandom_range(40, PIC_W - 60), $urandom_range(40, PIC_H - 60),
            int'($urandom_range(0, 60)) - 30, int'($urandom_range(0, 60)) - 30,
            $urandom_range(0, 15), $urandom_range(0, 15),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0);
    end
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ref_fetch_addr_gen.md
REF_FETCH_ADDR_GEN -- requirements
Module: ref_fetch_addr_gen

Interface
REQ-001 SHALL have parameter PIC_W, 416, picture width in samples.
REQ-002 SHALL have parameter PIC_H, 240, picture height in samples.
REQ-003 SHALL have parameter ADDR_W, 17, sample address width (PIC_W*PIC_H <= 2^ADDR_W).
REQ-004 SHALL have CLK input 1: single clock, all state on rising edge.
REQ-005 SHALL have RST_ASYNC input 1: reset, asynchronous, active-high.
REQ-006 SHALL have MV_VALID input 1 and MV_READY output 1: request handshake from MV generator.
REQ-007 SHALL have MV_X_INT, MV_Y_INT inputs 15 signed: integer MV parts.
REQ-008 SHALL have MV_X_FRAC, MV_Y_FRAC inputs 4: 1/16 fractional MV parts.
REQ-009 SHALL have INTERP_X, INTERP_Y inputs 1: horizontal/vertical interpolation needed.
REQ-010 SHALL have BLK_X, BLK_Y inputs 12 unsigned: top-left sample position of the 4x4 block.
REQ-011 SHALL have ADDR_VALID output 1 and ADDR_READY input 1: address handshake to reference memory.
REQ-012 SHALL have ADDR output ADDR_W: linear sample address row*PIC_W+col.
REQ-013 SHALL have ADDR_EOL output 1 (last column of row) and ADDR_LAST output 1 (last address of window).
REQ-014 SHALL have FRAC_X, FRAC_Y outputs 4 and OUT_INTERP_X, OUT_INTERP_Y outputs 1: request attributes latched at accept.

Function
REQ-015 SHALL implement FSM IDLE/FETCH; IDLE -> FETCH on MV_VALID&&MV_READY; FETCH -> IDLE on handshake with ADDR_LAST=1.
REQ-016 SHALL drive MV_READY=1 only in IDLE; request inputs sampled only on accept.
REQ-017 SHALL define window: x0 = BLK_X+MV_X_INT-(INTERP_X?3:0), width W = INTERP_X?11:4; y0, H likewise from Y inputs; arithmetic in 17-bit signed, no overflow.
REQ-018 SHALL emit W*H addresses in raster order (column fastest), one per ADDR_VALID&&ADDR_READY handshake.
REQ-019 SHALL assert ADDR_VALID from the cycle after accept (latency 1), continuously until final handshake.
REQ-020 SHALL hold ADDR, ADDR_EOL, ADDR_LAST stable while ADDR_VALID=1 and ADDR_READY=0.
REQ-021 SHALL assert ADDR_EOL when column counter = W-1; ADDR_LAST when additionally row counter = H-1.
REQ-022 SHALL keep FRAC_*/OUT_INTERP_* stable from accept until next accept.
REQ-023 SHALL return MV_READY=1 the cycle after the final handshake; back-to-back requests thus have one idle address cycle.
REQ-024 SHALL register ADDR (multiply by PIC_W via constant multiply or row-base accumulator; no combinational path from ADDR_READY to ADDR).

Reset
REQ-025 SHALL, on RST_ASYNC=1, immediately force state IDLE, MV_READY=1 after release, ADDR_VALID=0, ADDR=0, ADDR_EOL=0, ADDR_LAST=0, FRAC_*=0, OUT_INTERP_*=0, counters=0.
REQ-026 SHALL abandon any in-progress window on reset; no address of it is emitted after release.

Configuration
REQ-027 SHALL, with FETCH_CLAMP_EN defined, clamp each column to [0,PIC_W-1] and each row to [0,PIC_H-1] before address formation (boundary padding).
REQ-028 SHALL, without FETCH_CLAMP_EN, form address from unclamped row/col truncated to ADDR_W bits (caller guarantees in-picture windows); clamp logic absent.

Verification
REQ-029 BLK(8,4), MV(2,1), no interp -> 16 addresses, first 2090, last 3341, ADDR_EOL on every 4th, ADDR_LAST on 16th.
REQ-030 BLK(16,16), MV(0,0), INTERP_X=INTERP_Y=1 -> 121 addresses, first 5421, last 9591, ADDR_EOL every 11th.
REQ-031 FETCH_CLAMP_EN, BLK(0,0), MV(-5,-5), both interp -> first 9 addresses 0, 10th 1, 11th 2, last 834.
REQ-032 ADDR_READY low 3 cycles after 5th address -> ADDR/flags frozen, 6th address correct after release, total count unchanged.
REQ-033 RST_ASYNC pulsed after 5 handshakes -> ADDR_VALID=0 same cycle, MV_READY=1 after release, new request starts at its own first address.
REQ-034 MV_VALID held high with two requests -> MV_READY=0 throughout first window, second accepted cycle after first ADDR_LAST handshake, FRAC_* update only then.
